// File: rtl/rx_block_align_130b.sv
// 128b/130b receive block aligner: hunts sync headers on one lane's serial stream,
// locks after LOCK_CNT good headers and emits header + payload per block. Optional err_cnt via RX_ERR_CNT_EN.
module rx_block_align_130b #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic         clk1,
  input  logic         rst1,
  input  logic         in_valid,
  input  logic         data_in,
  output logic         blk_valid,
  output logic [1:0]   blk_hdr,
  output logic [127:0] blk_data,
  output logic         hdr_err,
  output logic         locked
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);
  localparam logic [7:0] BLK_LEN  = 8'd130;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  typedef struct packed {
    logic [1:0]   hdr;
    logic [127:0] data;
    logic         err;
  } blk_t;

  state_t       state, state_nxt;
  logic [129:0] window, win_nxt, cand;
  logic [7:0]   fill_cnt, fill_nxt, bit_cnt, bit_nxt, bit_inc;
  logic [3:0]   good, good_nxt, bad, bad_nxt;
  logic         hdr_ok, full, at_eval, emit, clr_err;
  logic         vld_q;
  blk_t         blk_q;

  assign cand    = {data_in, window[129:1]};
  assign hdr_ok  = cand[1] ^ cand[0];
  assign bit_inc = bit_cnt + 8'd1;
  assign at_eval = (bit_inc == BLK_LEN);

  always_comb begin
    win_nxt   = window;
    fill_nxt  = fill_cnt;
    bit_nxt   = bit_cnt;
    good_nxt  = good;
    bad_nxt   = bad;
    state_nxt = state;
    emit      = 1'b0;
    clr_err   = 1'b0;
    // window counts as full once this accepted bit is the 130th since reset
    full      = (fill_cnt >= BLK_LEN - 8'd1);
    if (in_valid) begin
      win_nxt = cand;
      if (fill_cnt != BLK_LEN) fill_nxt = fill_cnt + 8'd1;
      unique case (state)
        SEARCH: begin
          if (full && hdr_ok) begin
            state_nxt = CHECK;
            good_nxt  = 4'd1;
            bit_nxt   = 8'd0;
            clr_err   = 1'b1;
          end
        end
        CHECK: begin
          bit_nxt = at_eval ? 8'd0 : bit_inc;
          if (at_eval) begin
            if (hdr_ok) begin
              good_nxt = good + 4'd1;
              if (good_nxt == LOCK_C) begin
                state_nxt = LOCKED;
                bad_nxt   = 4'd0;
                emit      = 1'b1;
              end
            end else begin
              state_nxt = SEARCH;
            end
          end
        end
        LOCKED: begin
          bit_nxt = at_eval ? 8'd0 : bit_inc;
          if (at_eval) begin
            emit = 1'b1;
            if (hdr_ok) begin
              bad_nxt = 4'd0;
            end else begin
              bad_nxt = bad + 4'd1;
              if (bad_nxt == UNLOCK_C) state_nxt = SEARCH;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state    <= SEARCH;
      window   <= '0;
      fill_cnt <= '0;
      bit_cnt  <= '0;
      good     <= '0;
      bad      <= '0;
      vld_q    <= 1'b0;
      blk_q    <= '0;
    end else begin
      state    <= state_nxt;
      window   <= win_nxt;
      fill_cnt <= fill_nxt;
      bit_cnt  <= bit_nxt;
      good     <= good_nxt;
      bad      <= bad_nxt;
      vld_q    <= emit;
      if (emit) blk_q <= '{hdr: cand[1:0], data: cand[129:2], err: ~hdr_ok};
    end
  end

  assign blk_valid = vld_q;
  assign blk_hdr   = blk_q.hdr;
  assign blk_data  = blk_q.data;
  assign hdr_err   = blk_q.err;
  assign locked    = (state == LOCKED);

`ifdef RX_ERR_CNT_EN
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1)                                      err_cnt <= '0;
    else if (clr_err)                              err_cnt <= '0;
    else if (emit && !hdr_ok && err_cnt != 8'hff)  err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rx_block_align_130b.sv
// Randomized bench for rx_block_align_130b against a bit-history reference model.
module tb_rx_block_align_130b;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 4;

  logic         clk1 = 1'b0;
  logic         rst1, in_valid, data_in;
  logic         blk_valid, hdr_err, locked;
  logic [1:0]   blk_hdr;
  logic [127:0] blk_data;
`ifdef RX_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  rx_block_align_130b #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .clk1(clk1), .rst1(rst1), .in_valid(in_valid), .data_in(data_in),
    .blk_valid(blk_valid), .blk_hdr(blk_hdr), .blk_data(blk_data),
    .hdr_err(hdr_err), .locked(locked)
`ifdef RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk1 = ~clk1;

  int n_chk = 0, n_fail = 0;

  // reference model: history of accepted bits, absolute bit positions for block boundaries
  bit           hist[$];
  int           n_acc, mode, nxt_eval, good, bad, e_errcnt;
  logic         e_valid, e_err;
  logic [1:0]   e_hdr;
  logic [127:0] e_data;
  int           lock_at, cyc;
  logic         was_locked;
  bit           gap_en, rnd_gap;
  bit           stim_q[$];
  bit           rec_en;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    n_acc = 0; mode = 0; nxt_eval = 0; good = 0; bad = 0; e_errcnt = 0;
    e_valid = 0; e_err = 0; e_hdr = '0; e_data = '0;
    lock_at = -1; was_locked = 0;
  endtask

  task automatic model_emit(input logic [1:0] h, input bit ok);
    e_valid = 1; e_hdr = h; e_err = !ok;
    for (int i = 0; i < 128; i++) e_data[i] = hist[i+2];
    if (!ok && e_errcnt < 255) e_errcnt++;
  endtask

  task automatic model_accept(input bit b);
    logic [1:0] h;
    bit ok;
    hist.push_back(b);
    if (hist.size() > 130) void'(hist.pop_front());
    n_acc++;
    e_valid = 0;
    if (hist.size() == 130) begin
      h  = {hist[1], hist[0]};
      ok = (h == 2'b01) || (h == 2'b10);
      case (mode)
        0: if (ok) begin mode = 1; good = 1; nxt_eval = n_acc + 130; e_errcnt = 0; end
        1: if (n_acc == nxt_eval) begin
             nxt_eval += 130;
             if (ok) begin
               good++;
               if (good == LOCK_CNT) begin mode = 2; bad = 0; model_emit(h, ok); end
             end else mode = 0;
           end
        default: if (n_acc == nxt_eval) begin
             nxt_eval += 130;
             model_emit(h, ok);
             if (ok) bad = 0;
             else begin bad++; if (bad == UNLOCK_CNT) mode = 0; end
           end
      endcase
    end
  endtask

  task automatic step(input bit v, input bit b);
    @(negedge clk1);
    in_valid = v; data_in = b;
    @(posedge clk1);
    cyc++;
    if (v) model_accept(b); else e_valid = 0;
    #1;
    chk("blk_valid", blk_valid, e_valid);
    chk("locked", locked, mode == 2);
    if (e_valid) begin
      chk("blk_hdr", blk_hdr, e_hdr);
      chk("blk_data", blk_data, e_data);
      chk("hdr_err", hdr_err, e_err);
    end
`ifdef RX_ERR_CNT_EN
    chk("err_cnt", err_cnt, e_errcnt);
`endif
    if (locked && !was_locked && lock_at < 0) lock_at = n_acc;
    was_locked = locked;
  endtask

  task automatic put(input bit b);
    if (rec_en) stim_q.push_back(b);
    if (gap_en && (cyc % 3 == 2)) step(0, 1'($urandom_range(0, 1)));
    if (rnd_gap) while ($urandom_range(0, 3) == 0) step(0, 1'($urandom_range(0, 1)));
    step(1, b);
  endtask

  task automatic send_block(input logic [1:0] hdr, input bit zero_pl);
    put(hdr[0]);
    put(hdr[1]);
    for (int i = 0; i < 128; i++) put(zero_pl ? 1'b0 : 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst1 = 1'b1; in_valid = 1'b0; data_in = 1'b0;
    #1;
    chk("rst_valid", blk_valid, 0);
    chk("rst_hdr", blk_hdr, 0);
    chk("rst_data", blk_data, 0);
    chk("rst_err", hdr_err, 0);
    chk("rst_locked", locked, 0);
`ifdef RX_ERR_CNT_EN
    chk("rst_errcnt", err_cnt, 0);
`endif
    model_reset();
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst1 = 1'b0;
  endtask

  initial begin
    cyc = 0; gap_en = 0; rnd_gap = 0; rec_en = 0;
    do_reset();

    // clean stream: zero lead makes the true offset the first valid candidate
    rec_en = 1;
    for (int i = 0; i < 37; i++) put(1'b0);
    for (int k = 0; k < 6; k++) send_block(2'b10, 0);
    rec_en = 0;
    chk("t1_lock_at", lock_at, 557);

    // same stream with one gap every three clocks
    do_reset();
    gap_en = 1;
    foreach (stim_q[i]) put(stim_q[i]);
    gap_en = 0;
    chk("t2_lock_at", lock_at, 557);

    // bad headers while locked, then a recovering good one
    send_block(2'b00, 0);
    send_block(2'b11, 0);
    send_block(2'b00, 0);
    send_block(2'b10, 0);
    chk("t3_lock_hold", locked, 1);
    for (int k = 0; k < 3; k++) send_block(2'b11, 0);
    chk("t3_lock_3bad", locked, 1);
    send_block(2'b11, 0);
    chk("t3_unlock", locked, 0);

    // CHECK aborted by a corrupt third header, then relock
    do_reset();
    for (int i = 0; i < 37; i++) put(1'b0);
    send_block(2'b10, 1);
    send_block(2'b10, 1);
    send_block(2'b00, 1);
    chk("t4_no_lock", locked, 0);
    for (int k = 0; k < 3; k++) send_block(2'b10, 1);
    chk("t4_pre_relock", locked, 0);
    send_block(2'b10, 1);
    chk("t4_relock", locked, 1);

    // async reset mid-block while locked
    put(1'b1); put(1'b0);
    for (int i = 0; i < 50; i++) put(1'b0);
    chk("t5_pre_rst_lock", locked, 1);
    do_reset();

    // random lead, headers, payload and gaps
    rnd_gap = 1;
    for (int i = 0; i < 37; i++) put(1'($urandom_range(0, 1)));
    for (int k = 0; k < 14; k++) begin
      int r;
      r = $urandom_range(0, 7);
      send_block(r == 0 ? 2'b00 : r == 1 ? 2'b11 : r == 2 ? 2'b01 : 2'b10, 0);
    end
    rnd_gap = 0;

    // first header evaluation happens on the 130th accepted bit
    do_reset();
    for (int k = 0; k < 4; k++) send_block(2'b01, 1);
    chk("t6_lock_at", lock_at, 520);

`ifdef RX_ERR_CNT_EN
    for (int k = 0; k < 100; k++) begin
      for (int j = 0; j < 3; j++) send_block(2'b11, 1);
      send_block(2'b10, 1);
    end
    chk("t7_err_sat", err_cnt, 255);
    for (int j = 0; j < 4; j++) send_block(2'b11, 1);
    chk("t7_unlock", locked, 0);
    send_block(2'b10, 1);
    chk("t7_err_clr", err_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
